// File: rtl/conv_pkg.sv
// Shared types and helpers for the streaming 3x3 convolution block.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  localparam int BYTE_W = 8;
  localparam int LANES  = 4;
  localparam int WORD_W = BYTE_W * LANES;
  localparam int TAPS   = 9;
  localparam int ACC_W  = 20;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-128);

  // Clamp a signed accumulator value into a signed byte.
  function automatic logic [BYTE_W-1:0] sat_byte(input logic signed [ACC_W-1:0] v);
    logic [BYTE_W-1:0] r;
    if (v > SAT_MAX)      r = 8'h7f;
    else if (v < SAT_MIN) r = 8'h80;
    else                  r = v[BYTE_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/mac3x3.sv
// 9-tap unsigned-pixel x signed-weight multiply-accumulate, two register stages:
// stage 1 holds the products, stage 2 holds the sum. Result is valid two cycles
// after in_valid.
module mac3x3
  import conv_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [TAPS*BYTE_W-1:0]     pix,
  input  logic [TAPS*BYTE_W-1:0]     wgt,
  output logic                       out_valid,
  output logic signed [ACC_W-1:0]    out_acc
);

  localparam int PROD_W = 2 * BYTE_W + 1;

  logic signed [PROD_W-1:0] prod_d [TAPS];
  logic signed [PROD_W-1:0] prod_q [TAPS];
  logic                     s1_valid;
  logic signed [ACC_W-1:0]  sum_d;

  // Per-tap products; pixel is zero-extended so it stays non-negative.
  always_comb begin
    for (int j = 0; j < TAPS; j++) begin
      prod_d[j] = PROD_W'($signed({1'b0, pix[j*BYTE_W +: BYTE_W]})) *
                  PROD_W'($signed(wgt[j*BYTE_W +: BYTE_W]));
    end
  end

  // Adder tree over the registered products, sign-extended to the accumulator width.
  always_comb begin
    sum_d = '0;
    for (int j = 0; j < TAPS; j++) begin
      sum_d = sum_d + ACC_W'(prod_q[j]);
    end
  end

  // Two pipeline stages with their valid flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      for (int j = 0; j < TAPS; j++) prod_q[j] <= '0;
    end else begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      out_acc   <= sum_d;
      for (int j = 0; j < TAPS; j++) prod_q[j] <= prod_d[j];
    end
  end

endmodule

// File: rtl/conv_stream_top.sv
// Streaming 3x3 convolution: load pixel and weight buffers over a 32-bit word
// port, then sweep every valid output position (kernel innermost), post-process
// each result to a signed byte and emit four bytes per output word.
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; o_valid/o_data are held stable until o_ready is seen.
module conv_stream_top
  import conv_pkg::*;
#(
  parameter int IMG_W = 34,
  parameter int IMG_H = 34,
  parameter int K_NUM = 16,
  parameter int SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] i_data,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic              d_type,
  input  logic              relu_en,
  output logic [WORD_W-1:0] o_data,
  output logic              o_valid,
  input  logic              o_ready,
  output logic              busy,
  output logic              finish,
  output state_t            dbg_state
);

  localparam int PIX_N   = IMG_W * IMG_H;
  localparam int WGT_N   = K_NUM * TAPS;
  localparam int OUT_W   = IMG_W - 2;
  localparam int OUT_H   = IMG_H - 2;
  localparam int N_WORDS = OUT_W * OUT_H * K_NUM / LANES;
  localparam int PP_W    = $clog2(PIX_N + 1);
  localparam int WP_W    = $clog2(WGT_N + 1);
  localparam int PA_W    = $clog2(PIX_N);
  localparam int WA_W    = $clog2(WGT_N);
  localparam int R_W     = $clog2(OUT_H + 1);
  localparam int C_W     = $clog2(OUT_W + 1);
  localparam int K_W     = $clog2(K_NUM + 1);
  localparam int NW_W    = $clog2(N_WORDS + 1);

  state_t                   state;
  logic [PP_W-1:0]          pix_ptr;
  logic [WP_W-1:0]          wgt_ptr;
  logic [R_W-1:0]           row_q;
  logic [C_W-1:0]           col_q;
  logic [K_W-1:0]           k_q;
  logic [NW_W-1:0]          word_cnt;
  logic                     relu_q;
  logic                     iss_d1;
  logic [BYTE_W-1:0]        pix_mem [PIX_N];
  logic [BYTE_W-1:0]        wgt_mem [WGT_N];
  logic [TAPS*BYTE_W-1:0]   pix_vec;
  logic [TAPS*BYTE_W-1:0]   wgt_vec;
  logic                     res_valid;
  logic signed [ACC_W-1:0]  res_acc;
  logic signed [ACC_W-1:0]  shifted;
  logic [BYTE_W-1:0]        res_byte;
  logic [1:0]               lane_q;
  logic [3*BYTE_W-1:0]      pack_q;
  logic [2:0]               occ;
  logic                     load_fire, pix_full, wgt_full, last_issue;
  logic                     stall, issue, out_done;

  assign dbg_state  = state;
  assign load_fire  = i_valid & i_ready;
  assign pix_full   = (pix_ptr == PP_W'(PIX_N));
  assign wgt_full   = (wgt_ptr == WP_W'(WGT_N));
  assign last_issue = (row_q == R_W'(OUT_H - 1)) && (col_q == C_W'(OUT_W - 1)) &&
                      (k_q == K_W'(K_NUM - 1));
  // Results that will eventually land in the packer: already packed + in flight.
  assign occ        = {1'b0, lane_q} + {2'b00, iss_d1} + {2'b00, res_valid};
  // Hold issue while the output word is blocked and one more result could complete the next word.
  assign stall      = o_valid && !o_ready && (occ >= 3'd3);
  assign issue      = (state == ST_COMPUTE) && !stall;
  assign out_done   = o_valid && o_ready && (word_cnt == NW_W'(N_WORDS - 1));

  // Buffer writes; words arriving for an already-full buffer are dropped.
  always_ff @(posedge clk) begin
    if (load_fire && !d_type && !pix_full) begin
      for (int b = 0; b < LANES; b++)
        pix_mem[PA_W'(pix_ptr + PP_W'(b))] <= i_data[b*BYTE_W +: BYTE_W];
    end
    if (load_fire && d_type && !wgt_full) begin
      for (int b = 0; b < LANES; b++)
        wgt_mem[WA_W'(wgt_ptr + WP_W'(b))] <= i_data[b*BYTE_W +: BYTE_W];
    end
  end

  // Gather the 3x3 pixel window and the current kernel's weights (tap j = 3*row+col).
  always_comb begin
    int pa;
    int wa;
    pa      = 0;
    wa      = 0;
    pix_vec = '0;
    wgt_vec = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        pa = (int'(row_q) + i) * IMG_W + int'(col_q) + j;
        wa = int'(k_q) * TAPS + 3 * i + j;
        pix_vec[(3*i+j)*BYTE_W +: BYTE_W] = pix_mem[PA_W'(pa)];
        wgt_vec[(3*i+j)*BYTE_W +: BYTE_W] = wgt_mem[WA_W'(wa)];
      end
    end
  end

  mac3x3 u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (issue),
    .pix       (pix_vec),
    .wgt       (wgt_vec),
    .out_valid (res_valid),
    .out_acc   (res_acc)
  );

  // Shift, optional ReLU, then saturate to a signed byte.
  always_comb begin
    shifted = res_acc >>> SHIFT;
    if (relu_q && shifted[ACC_W-1]) shifted = '0;
    res_byte = sat_byte(shifted);
  end

  // Run control: load, sweep positions/kernels, wait for the last word to leave.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      i_ready  <= 1'b0;
      busy     <= 1'b0;
      finish   <= 1'b0;
      relu_q   <= 1'b0;
      pix_ptr  <= '0;
      wgt_ptr  <= '0;
      row_q    <= '0;
      col_q    <= '0;
      k_q      <= '0;
      word_cnt <= '0;
      iss_d1   <= 1'b0;
    end else begin
      finish <= 1'b0;
      iss_d1 <= issue;
      if (o_valid && o_ready) word_cnt <= word_cnt + NW_W'(1);
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_LOAD;
            i_ready  <= 1'b1;
            busy     <= 1'b1;
            relu_q   <= relu_en;
            pix_ptr  <= '0;
            wgt_ptr  <= '0;
            row_q    <= '0;
            col_q    <= '0;
            k_q      <= '0;
            word_cnt <= '0;
          end
        end
        ST_LOAD: begin
          if (load_fire) begin
            if (d_type) begin
              if (!wgt_full) wgt_ptr <= wgt_ptr + WP_W'(LANES);
            end else if (!pix_full) begin
              pix_ptr <= pix_ptr + PP_W'(LANES);
            end
          end
          if (pix_full && wgt_full) begin
            state   <= ST_COMPUTE;
            i_ready <= 1'b0;
          end
        end
        ST_COMPUTE: begin
          if (issue) begin
            if (last_issue) begin
              row_q <= '0;
              col_q <= '0;
              k_q   <= '0;
              state <= ST_DRAIN;
            end else if (k_q == K_W'(K_NUM - 1)) begin
              k_q <= '0;
              if (col_q == C_W'(OUT_W - 1)) begin
                col_q <= '0;
                row_q <= row_q + R_W'(1);
              end else begin
                col_q <= col_q + C_W'(1);
              end
            end else begin
              k_q <= k_q + K_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (out_done) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            finish <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Pack four results per word, first result in byte 0; hold the word until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q  <= '0;
      pack_q  <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      if (o_valid && o_ready) o_valid <= 1'b0;
      if (res_valid) begin
        if (lane_q == 2'd3) begin
          o_data  <= {res_byte, pack_q};
          o_valid <= 1'b1;
          lane_q  <= '0;
        end else begin
          pack_q[{lane_q, 3'b000} +: BYTE_W] <= res_byte;
          lane_q <= lane_q + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_stream_top.sv
// Bench for conv_stream_top on a 6x6 image, 4 kernels, shift of 2.
module tb_conv_stream_top;
  import conv_pkg::*;

  localparam int TW     = 6;
  localparam int TH     = 6;
  localparam int TK     = 4;
  localparam int TS     = 2;
  localparam int NPIX   = TW * TH;
  localparam int NWGT   = TK * 9;
  localparam int NWORDS = (TW - 2) * (TH - 2) * TK / 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        i_valid = 1'b0;
  logic        d_type = 1'b0;
  logic        relu_en = 1'b0;
  logic        o_ready = 1'b0;
  logic [31:0] i_data = '0;
  logic        i_ready, o_valid, busy, finish;
  logic [31:0] o_data;
  state_t      dbg_state;

  int          checks = 0;
  int          errors = 0;
  int          pix_m [NPIX];
  int          wgt_m [NWGT];
  logic [31:0] exp_q [$];
  bit          ready_rand = 0;
  bit          stall_mode = 0;
  bit          interleave = 0;

  conv_stream_top #(.IMG_W(TW), .IMG_H(TH), .K_NUM(TK), .SHIFT(TS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .d_type    (d_type),
    .relu_en   (relu_en),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .busy      (busy),
    .finish    (finish),
    .dbg_state (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    logic [31:0] r;
    r = {d[7:0], c[7:0], b[7:0], a[7:0]};
    return r;
  endfunction

  task automatic build_expected(input bit relu);
    int acc;
    int lane;
    logic [31:0] w;
    exp_q.delete();
    w = '0;
    lane = 0;
    for (int r = 0; r < TH - 2; r++)
      for (int c = 0; c < TW - 2; c++)
        for (int k = 0; k < TK; k++) begin
          acc = 0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              acc += pix_m[(r + i) * TW + c + j] * wgt_m[k * 9 + 3 * i + j];
          acc = acc >>> TS;
          if (relu && acc < 0) acc = 0;
          if (acc > 127) acc = 127;
          if (acc < -128) acc = -128;
          w[lane*8 +: 8] = acc[7:0];
          lane++;
          if (lane == 4) begin
            exp_q.push_back(w);
            w = '0;
            lane = 0;
          end
        end
  endtask

  task automatic fill(input int pmin, input int pmax, input int wmin, input int wmax);
    for (int i = 0; i < NPIX; i++) pix_m[i] = int'($urandom_range(pmax - pmin, 0)) + pmin;
    for (int i = 0; i < NWGT; i++) wgt_m[i] = int'($urandom_range(wmax - wmin, 0)) + wmin;
  endtask

  // ---------------- drivers ----------------
  task automatic drive_word(input bit dt, input logic [31:0] data);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    i_valid = 1'b1;
    d_type  = dt;
    i_data  = data;
    while (!acc && n < 200) begin
      acc = i_ready;
      @(negedge clk);
      n++;
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL load_accept: i_ready=%0b after %0d cycles, required 1", i_ready, n);
    end
  endtask

  task automatic load_all();
    int pw;
    int ww;
    pw = 0;
    ww = 0;
    if (interleave) begin
      while (ww < NWGT / 4) begin
        drive_word(1'b1, pack4(wgt_m[4*ww], wgt_m[4*ww+1], wgt_m[4*ww+2], wgt_m[4*ww+3]));
        ww++;
        if (ww < NWGT / 4) begin
          drive_word(1'b1, pack4(wgt_m[4*ww], wgt_m[4*ww+1], wgt_m[4*ww+2], wgt_m[4*ww+3]));
          ww++;
        end
        if (pw < NPIX / 4) begin
          drive_word(1'b0, pack4(pix_m[4*pw], pix_m[4*pw+1], pix_m[4*pw+2], pix_m[4*pw+3]));
          pw++;
        end
      end
      drive_word(1'b1, $urandom());
      drive_word(1'b1, $urandom());
    end
    while (pw < NPIX / 4) begin
      drive_word(1'b0, pack4(pix_m[4*pw], pix_m[4*pw+1], pix_m[4*pw+2], pix_m[4*pw+3]));
      pw++;
    end
    while (ww < NWGT / 4) begin
      drive_word(1'b1, pack4(wgt_m[4*ww], wgt_m[4*ww+1], wgt_m[4*ww+2], wgt_m[4*ww+3]));
      ww++;
    end
    i_valid = 1'b0;
    d_type  = 1'b0;
  endtask

  task automatic kick(input bit relu);
    start   = 1'b1;
    relu_en = relu;
    @(negedge clk);
    start   = 1'b0;
    relu_en = !relu;
  endtask

  // A stray start (with flipped relu_en) while busy must change nothing.
  task automatic stray_start();
    repeat (2) @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  task automatic collect(input string name);
    int got;
    int cyc;
    int hold;
    bit seen;
    logic [31:0] held;
    logic [31:0] exp;
    got = 0;
    cyc = 0;
    hold = 0;
    seen = 0;
    held = '0;
    while (got < NWORDS && cyc < 3000) begin
      if (stall_mode && !seen && o_valid) begin
        seen = 1;
        hold = 20;
        held = o_data;
        o_ready = 1'b0;
      end else if (hold > 0) begin
        checks++;
        if (o_data !== held || o_valid !== 1'b1) begin
          errors++;
          $display("FAIL %s stall_hold: o_valid=%0b o_data=%08h, required 1 and %08h", name, o_valid, o_data, held);
        end
        hold--;
        o_ready = 1'b0;
      end else begin
        o_ready = ready_rand ? ($urandom_range(3, 0) != 0) : 1'b1;
      end
      if (o_valid && o_ready) begin
        exp = exp_q.pop_front();
        checks++;
        if (o_data !== exp) begin
          errors++;
          $display("FAIL %s word%0d: o_data=%08h, required %08h", name, got, o_data, exp);
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    o_ready = 1'b0;
    checks++;
    if (got < NWORDS) begin
      errors++;
      $display("FAIL %s word_count: got %0d words, required %0d", name, got, NWORDS);
    end else begin
      checks++;
      if (finish !== 1'b1 || busy !== 1'b0 || o_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s end_of_run: finish=%0b busy=%0b o_valid=%0b, required 1 0 0", name, finish, busy, o_valid);
      end
      @(negedge clk);
      checks++;
      if (finish !== 1'b0 || o_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s finish_pulse: finish=%0b o_valid=%0b, required 0 0", name, finish, o_valid);
      end
    end
  endtask

  task automatic run_check(input string name, input bit relu);
    build_expected(relu);
    kick(relu);
    fork
      begin
        load_all();
        stray_start();
      end
      collect(name);
    join
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || busy !== 1'b0 || finish !== 1'b0 || i_ready !== 1'b0 ||
        o_data !== 32'h0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: o_valid=%0b busy=%0b finish=%0b i_ready=%0b o_data=%08h state=%0d, required all 0",
               o_valid, busy, finish, i_ready, o_data, dbg_state);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (i_ready !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start: i_ready=%0b busy=%0b, required 0 0", i_ready, busy);
    end
  endtask

  task automatic test_all_ones();
    for (int i = 0; i < NPIX; i++) pix_m[i] = 1;
    for (int i = 0; i < NWGT; i++) wgt_m[i] = 1;
    ready_rand = 0;
    run_check("all_ones", 1'b0);
  endtask

  task automatic test_neg_relu();
    for (int i = 0; i < NPIX; i++) pix_m[i] = 1;
    for (int i = 0; i < NWGT; i++) wgt_m[i] = -1;
    ready_rand = 0;
    run_check("neg_norelu", 1'b0);
    run_check("neg_relu", 1'b1);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < NPIX; i++) pix_m[i] = 255;
    for (int i = 0; i < NWGT; i++) wgt_m[i] = 127;
    ready_rand = 0;
    run_check("sat_pos", 1'b0);
    for (int i = 0; i < NWGT; i++) wgt_m[i] = -128;
    run_check("sat_neg", 1'b0);
  endtask

  task automatic test_random();
    ready_rand = 1;
    fill(0, 255, -128, 127);
    run_check("rand_full", $urandom_range(1, 0) == 1);
    fill(0, 15, -3, 3);
    run_check("rand_small", 1'b0);
    fill(0, 15, -3, 3);
    run_check("rand_small_relu", 1'b1);
    ready_rand = 0;
  endtask

  task automatic test_stall();
    fill(0, 31, -4, 4);
    stall_mode = 1;
    run_check("stall", 1'b0);
    stall_mode = 0;
  endtask

  task automatic test_interleave();
    fill(0, 31, -4, 4);
    interleave = 1;
    ready_rand = 1;
    run_check("interleave", 1'b1);
    interleave = 0;
    ready_rand = 0;
  endtask

  task automatic test_mid_reset();
    int bad;
    fill(0, 255, -128, 127);
    kick(1'b0);
    o_ready = 1'b0;
    load_all();
    repeat (6) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || i_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_precond: busy=%0b i_ready=%0b, required 1 0", busy, i_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || busy !== 1'b0 || finish !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL mid_reset_async: o_valid=%0b busy=%0b finish=%0b state=%0d, required 0 0 0 0",
               o_valid, busy, finish, dbg_state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    o_ready = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    o_ready = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_reset_abort: %0d cycles with o_valid/busy set after abort, required 0", bad);
    end
    fill(0, 63, -8, 8);
    run_check("after_reset", 1'b0);
  endtask

  task automatic test_back_to_back();
    fill(0, 255, -16, 16);
    run_check("b2b_a", 1'b0);
    fill(0, 255, -16, 16);
    run_check("b2b_b", 1'b1);
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_neg_relu();
    test_saturation();
    test_random();
    test_stall();
    test_interleave();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
